// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;
  localparam int TIMEOUT_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arb_timer.sv
// Saturating busy-cycle counter; expired flags the cycle in which the count reaches TIMEOUT.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
)(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [TIMEOUT_W:0] LIMIT = TIMEOUT[TIMEOUT_W:0];

  logic [TIMEOUT_W-1:0] cnt;
  logic [TIMEOUT_W:0]   cnt_nxt;

  assign cnt_nxt = {1'b0, cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
  // Look at the value this cycle would produce so TIMEOUT busy cycles means exactly TIMEOUT.
  assign expired = en && (cnt_nxt >= LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt_nxt[TIMEOUT_W-1:0];
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (I) and data (D) requesters.
// Define MEM_ARB_RR_EN for round-robin priority; default is data-first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, x_addr;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q, busy, x_req, finish, expired, post_rst;
  logic              idle_go, pick_d, gnt_i, gnt_d, err_set;

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;
  assign busy    = (state != IDLE);
  assign finish  = busy & (mem_done | expired);
  assign x_req   = (state == BUSY_D) ? d_req  : i_req;
  assign x_addr  = (state == BUSY_D) ? d_addr : i_addr;
  // The done cycle never grants, so a requester still holding req is not re-served.
  assign idle_go = ~rst & ~i_done & ~d_done;

`ifdef MEM_ARB_RR_EN
  logic last_grant;
  assign pick_d = d_req & (~i_req | ~last_grant);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_grant <= 1'b1;
    else if (gnt_i) last_grant <= 1'b0;
    else if (gnt_d) last_grant <= 1'b1;
  end
`else
  assign pick_d = d_req;
`endif

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (~busy | finish),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Start pulse presents the request's own address/data; the latches hold them afterwards.
  always_comb begin
    state_nxt = state;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    unique case (state)
      IDLE: if (idle_go) begin
        if (pick_d) begin
          gnt_d = 1'b1; mem_en = 1'b1; mem_wr = d_wr;
          mem_addr = d_addr; mem_wdata = d_wdata; state_nxt = BUSY_D;
        end else if (i_req) begin
          gnt_i = 1'b1; mem_en = 1'b1; mem_addr = i_addr; state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A stray mem_done right after reset belongs to the abandoned access and is not an error.
  assign err_set = (busy & (~x_req | (x_addr != addr_q) | (expired & ~mem_done)))
                 | (~busy & mem_done & ~post_rst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0; wdata_q <= '0; wr_q <= 1'b0; post_rst <= 1'b1;
      i_rdata <= '0; d_rdata <= '0; i_done <= 1'b0; d_done <= 1'b0; err <= 1'b0;
    end else begin
      post_rst <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      if (gnt_d) begin
        addr_q <= d_addr; wdata_q <= d_wdata; wr_q <= d_wr;
      end else if (gnt_i) begin
        addr_q <= i_addr; wr_q <= 1'b0;
      end
      if (finish) begin
        if (state == BUSY_I) begin
          i_done  <= 1'b1;
          i_rdata <= mem_done ? mem_rdata : '0;
        end else begin
          d_done <= 1'b1;
          if (!mem_done)  d_rdata <= '0;
          else if (!wr_q) d_rdata <= mem_rdata;
        end
      end
      if (err_set) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;
  localparam int TO = 15;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr, err, mem_done;
  logic        mdl_done = 1'b0, inj_done = 1'b0;

  assign mem_done = mdl_done | inj_done;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } en_t;
  en_t         en_log[$];
  logic [15:0] mem_arr [logic [15:0]];
  logic [15:0] exp_i[$], exp_d[$];
  logic [15:0] d_hold = '0;
  int          mem_lat = 1;
  bit          mem_mute = 1'b0;
  int          checks = 0, passed = 0;

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : (16'hBEEF ^ a);
  endfunction

  // Memory: records every start pulse, answers mem_lat cycles later unless muted.
  initial begin : mem_model
    int cd; logic [15:0] a; logic w; en_t e;
    cd = 0; a = '0; w = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        e.cyc = cyc; e.wr = mem_wr; e.addr = mem_addr; e.wdata = mem_wdata;
        en_log.push_back(e);
        cd = mem_lat; a = mem_addr; w = mem_wr;
        if (mem_wr) mem_arr[mem_addr] = mem_wdata;
      end
      @(posedge clk); #1;
      mdl_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !mem_mute) begin
          mdl_done = 1'b1; mem_rdata = w ? 16'h0 : rd(a);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({mem_en, mem_wr, i_done, d_done, i_stall, d_stall, err} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000", {mem_en, mem_wr, i_done, d_done, i_stall, d_stall, err}); else passed++;
    checks++; if ({mem_addr, mem_wdata} !== 32'h0)
      $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); else passed++;
    checks++; if ({i_rdata, d_rdata} !== 32'h0)
      $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata}); else passed++;
    step(); rst = 1'b0; step();
    @(negedge clk);
    checks++; if ({mem_en, err} !== 2'b0)
      $display("FAIL reset_release: got %b want 00", {mem_en, err}); else passed++;
  endtask

  task automatic test_contention();
    int di, dd, s, fd;
    logic [15:0] a1, a2; logic w1, w2;
    en_t wr_e;
    en_log.delete(); mem_mute = 1'b0; mem_lat = 1;
    step();
    i_addr = 16'h0010; d_addr = 16'h0200; d_wdata = 16'h1234; d_wr = 1'b1;
    i_req = 1'b1; d_req = 1'b1; s = cyc;
    exp_i.push_back(rd(16'h0010)); exp_d.push_back(d_hold);
    di = -1; dd = -1;
    for (int c = 0; c < 30 && (di < 0 || dd < 0); c++) begin
      @(negedge clk);
      if (i_done) begin
        logic [15:0] want; want = exp_i.size() ? exp_i.pop_front() : 16'hxxxx;
        checks++; if (i_rdata !== want) $display("FAIL cont_i_rdata: got %h want %h", i_rdata, want); else passed++;
        di = cyc;
      end
      if (d_done) begin
        logic [15:0] want; want = exp_d.size() ? exp_d.pop_front() : 16'hxxxx;
        checks++; if (d_rdata !== want) $display("FAIL cont_d_rdata: got %h want %h", d_rdata, want); else passed++;
        dd = cyc;
      end
      step();
      if (di >= 0) i_req = 1'b0;
      if (dd >= 0) d_req = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    checks++; if (di < 0 || dd < 0) $display("FAIL cont_both_done: got i=%0d d=%0d want both >=0", di, dd); else passed++;
`ifdef MEM_ARB_RR_EN
    a1 = 16'h0010; w1 = 1'b0; a2 = 16'h0200; w2 = 1'b1;
`else
    a1 = 16'h0200; w1 = 1'b1; a2 = 16'h0010; w2 = 1'b0;
`endif
    fd = w1 ? dd : di;
    checks++;
    if (en_log.size() != 2) $display("FAIL cont_grants: got %0d starts want 2", en_log.size());
    else begin
      wr_e = w1 ? en_log[0] : en_log[1];
      if ({en_log[0].wr, en_log[0].addr, en_log[1].wr, en_log[1].addr} !== {w1, a1, w2, a2})
        $display("FAIL cont_order: got %b/%h %b/%h want %b/%h %b/%h",
                 en_log[0].wr, en_log[0].addr, en_log[1].wr, en_log[1].addr, w1, a1, w2, a2);
      else if (en_log[0].cyc != s || en_log[1].cyc != fd + 1)
        $display("FAIL cont_timing: got %0d,%0d want %0d,%0d", en_log[0].cyc, en_log[1].cyc, s, fd + 1);
      else if (wr_e.wdata !== 16'h1234)
        $display("FAIL cont_wdata: got %h want 1234", wr_e.wdata);
      else passed++;
    end
  endtask

  task automatic test_fetch();
    int s; bit seen;
    en_log.delete(); mem_mute = 1'b0; mem_lat = 3; seen = 1'b0;
    step();
    i_addr = 16'h0010; i_req = 1'b1; s = cyc;
    exp_i.push_back(16'hA5A5);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (i_done !== (cyc == s + 4)) $display("FAIL fetch_done_cyc%0d: got %b want %b", c, i_done, cyc == s + 4); else passed++;
      if (!seen) begin
        checks++; if (i_stall !== (cyc != s + 4)) $display("FAIL fetch_stall_cyc%0d: got %b want %b", c, i_stall, cyc != s + 4); else passed++;
      end
      if (i_done) begin
        logic [15:0] want; want = exp_i.size() ? exp_i.pop_front() : 16'hxxxx;
        checks++; if (i_rdata !== want) $display("FAIL fetch_rdata: got %h want %h", i_rdata, want); else passed++;
        seen = 1'b1;
      end
      step();
      if (seen) i_req = 1'b0;
    end
    checks++; if (en_log.size() != 1 || err !== 1'b0)
      $display("FAIL fetch_single_start: got starts=%0d err=%b want 1 0", en_log.size(), err); else passed++;
  endtask

  task automatic test_back_to_back();
    int s, nd;
    en_log.delete(); mem_mute = 1'b0; mem_lat = 1; nd = 0;
    mem_arr[16'h0600] = 16'h1111; mem_arr[16'h0602] = 16'h2222;
    step();
    d_wr = 1'b0; d_addr = 16'h0600; d_req = 1'b1; s = cyc;
    exp_d.push_back(rd(16'h0600)); exp_d.push_back(rd(16'h0602));
    d_hold = rd(16'h0602);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++; if (d_done !== (cyc == s + 2 || cyc == s + 5))
        $display("FAIL b2b_done_cyc%0d: got %b want %b", c, d_done, cyc == s + 2 || cyc == s + 5); else passed++;
      if (d_done) begin
        logic [15:0] want; want = exp_d.size() ? exp_d.pop_front() : 16'hxxxx;
        checks++; if (d_rdata !== want) $display("FAIL b2b_rdata%0d: got %h want %h", nd, d_rdata, want); else passed++;
        nd++;
      end
      step();
      if (nd == 1) d_addr = 16'h0602;
      if (nd == 2) d_req = 1'b0;
    end
    d_req = 1'b0;
    checks++;
    if (en_log.size() != 2) $display("FAIL b2b_starts: got %0d want 2", en_log.size());
    else if (en_log[1].cyc - en_log[0].cyc != 3) $display("FAIL b2b_gap: got %0d want 3", en_log[1].cyc - en_log[0].cyc);
    else passed++;
  endtask

  task automatic test_timeout();
    int s; bit seen;
    en_log.delete(); mem_mute = 1'b1; mem_lat = 1; seen = 1'b0;
    step();
    d_wr = 1'b0; d_addr = 16'h0300; d_req = 1'b1; s = cyc;
    exp_d.push_back(16'h0000); d_hold = 16'h0000;
    for (int c = 0; c < TO + 4; c++) begin
      @(negedge clk);
      checks++; if (d_done !== (cyc == s + TO + 1)) $display("FAIL to_done_cyc%0d: got %b want %b", c, d_done, cyc == s + TO + 1); else passed++;
      checks++; if (err !== (cyc >= s + TO + 1)) $display("FAIL to_err_cyc%0d: got %b want %b", c, err, cyc >= s + TO + 1); else passed++;
      if (d_done) begin
        logic [15:0] want; want = exp_d.size() ? exp_d.pop_front() : 16'hxxxx;
        checks++; if (d_rdata !== want) $display("FAIL to_rdata: got %h want %h", d_rdata, want); else passed++;
        seen = 1'b1;
      end
      step();
      if (seen) d_req = 1'b0;
    end
    d_req = 1'b0;
    inj_done = 1'b1; step(); inj_done = 1'b0;
    @(negedge clk);
    checks++; if ({err, d_done, i_done, d_stall} !== 4'b1000 || en_log.size() != 1)
      $display("FAIL to_late_done: got err/dd/id/ds=%b starts=%0d want 1000 1", {err, d_done, i_done, d_stall}, en_log.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int s; bit seen;
    mem_mute = 1'b1; mem_lat = 2; seen = 1'b0;
    step();
    d_wr = 1'b0; d_addr = 16'h0400; d_req = 1'b1;
    step(); step();
    rst = 1'b1; d_req = 1'b0;
    #1;
    checks++; if ({mem_en, mem_wr, i_done, d_done, i_stall, d_stall, err} !== 7'b0)
      $display("FAIL rstmid_ctrl: got %b want 0000000", {mem_en, mem_wr, i_done, d_done, i_stall, d_stall, err}); else passed++;
    checks++; if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0)
      $display("FAIL rstmid_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata}); else passed++;
    step(); step();
    rst = 1'b0; inj_done = 1'b1;
    step(); inj_done = 1'b0;
    @(negedge clk);
    checks++; if ({err, d_done} !== 2'b00) $display("FAIL rstmid_stray_done: got %b want 00", {err, d_done}); else passed++;
    en_log.delete(); mem_mute = 1'b0; mem_lat = 1;
    step();
    i_addr = 16'h0500; i_req = 1'b1; s = cyc;
    exp_i.push_back(rd(16'h0500));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (i_done) begin
        logic [15:0] want; want = exp_i.size() ? exp_i.pop_front() : 16'hxxxx;
        checks++; if (i_rdata !== want || cyc != s + 2)
          $display("FAIL rstmid_fetch: got %h@%0d want %h@%0d", i_rdata, cyc, want, s + 2); else passed++;
        seen = 1'b1;
      end
      step();
      if (seen) i_req = 1'b0;
    end
    i_req = 1'b0;
    checks++; if (!seen || err !== 1'b0) $display("FAIL rstmid_regrant: got done=%b err=%b want 1 0", seen, err); else passed++;
  endtask

  task automatic test_protocol();
    int s; bit seen;
    en_log.delete(); mem_mute = 1'b0; mem_lat = 3; seen = 1'b0;
    step();
    i_addr = 16'h0010; i_req = 1'b1; s = cyc;
    exp_i.push_back(16'hA5A5);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++; if (err !== (cyc >= s + 2)) $display("FAIL proto_err_cyc%0d: got %b want %b", c, err, cyc >= s + 2); else passed++;
      if (i_done) begin
        logic [15:0] want; want = exp_i.size() ? exp_i.pop_front() : 16'hxxxx;
        checks++; if (i_rdata !== want || cyc != s + 4)
          $display("FAIL proto_complete: got %h@%0d want %h@%0d", i_rdata, cyc, want, s + 4); else passed++;
        seen = 1'b1;
      end
      step();
      if (cyc == s + 1) i_addr = 16'h0012;
      if (seen) begin i_req = 1'b0; i_addr = 16'h0010; end
    end
    i_req = 1'b0;
    checks++; if (!seen) $display("FAIL proto_done_seen: got 0 want 1"); else passed++;
  endtask

  initial begin
    mem_arr[16'h0010] = 16'hA5A5;
    test_reset();
    test_contention();
    test_fetch();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between the fetch stage (instruction reads) and the memory stage (data reads and writes) of the processor.
- Sequences each access as a request/done transaction with a three-state FSM.
- Produces stall signals that the processor uses to freeze PC and pipeline state.
- Output `err` is ORed into the top-level `err` with the other sub-module error outputs.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum cycles to wait for `mem_done` before the access is aborted; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_req  input  1  fetch read request; held high until `i_done`.
- i_addr  input  ADDR_W  fetch address; must be stable while `i_req` is pending.
- i_rdata  output  DATA_W  fetched instruction; valid when `i_done`=1.
- i_done  output  1  one-cycle completion pulse for the fetch request.
- i_stall  output  1  = i_req & ~i_done (combinational).
- d_req  input  1  data request; held high until `d_done`.
- d_wr  input  1  1 = write, 0 = read; sampled at grant.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_rdata  output  DATA_W  read data; valid when `d_done`=1.
- d_done  output  1  one-cycle completion pulse for the data request.
- d_stall  output  1  = d_req & ~d_done (combinational).
- mem_en  output  1  one-cycle start pulse to the memory.
- mem_wr  output  1  write enable, qualified by `mem_en`.
- mem_addr  output  ADDR_W  registered address; held for the whole transaction.
- mem_wdata  output  DATA_W  registered write data.
- mem_rdata  input  DATA_W  memory read data; valid with `mem_done`.
- mem_done  input  1  memory completion pulse; may arrive 1 or more cycles after `mem_en`.
- err  output  1  sticky error flag; cleared only by `rst`.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and the timeout counter is 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If d_req: latch d_addr, d_wdata and d_wr; pulse mem_en; go to BUSY_D.
  - Else if i_req: latch i_addr; pulse mem_en with mem_wr=0; go to BUSY_I.
  - Grant and mem_en happen in the same cycle the request is first seen; minimum request-to-done latency is 2 cycles.
- BUSY_x:
  - The counter increments every cycle.
  - On mem_done: register mem_rdata into x_rdata, pulse x_done on the next cycle, clear the counter, return to IDLE.
  - For writes, d_rdata is left unchanged.
  - The cycle in which x_done is high counts as IDLE, but that requester's req is ignored for that cycle so a held req is not re-granted. The next grant can come one cycle later, so back-to-back accesses are separated by 1 idle cycle.
- Priority: the data requester wins whenever both requests are pending in IDLE. Data is the older instruction in the pipeline, so this ordering is required for forward progress.
- Timeout:
  - If the counter reaches TIMEOUT without mem_done: set err, pulse x_done with x_rdata = 16'h0000, return to IDLE.
  - A late mem_done for the aborted access is ignored and sets err.
- Error conditions that set err:
  - mem_done arriving in IDLE.
  - Timeout.
  - The granted requester dropping req before done.
  - The granted requester changing addr before done (checked every BUSY cycle).
- Simultaneous events:
  - mem_done in the same cycle the counter hits TIMEOUT: mem_done wins and no error is raised.
  - The non-granted requester may assert or deassert req freely.
- Reset mid-transaction: return to IDLE immediately and drop all done pulses. The outstanding memory access is abandoned. A mem_done arriving in the first cycle after reset is ignored without error.
- The counter width is 8 bits and saturates at 255.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- When defined: round-robin priority. A 1-bit `last_grant` register is set at each grant (0=I, 1=D). When both requests are pending, the requester not equal to last_grant wins. last_grant resets to 1, so the first contended grant goes to I.
- When undefined: fixed data-first priority and no last_grant register.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2);
  - the default widths;
  - TIMEOUT_W=8.
- Sub-module mem_arb_timer: the 8-bit saturating counter, with clear and enable inputs and an `expired` output compared against TIMEOUT.
- Everything else (FSM, latches, error logic) lives in the top module.

Test Plan:
- Fetch only: i_req with addr 16'h0010, mem_done 3 cycles after mem_en with rdata 16'hA5A5 -> exactly one mem_en; i_done pulses once with i_rdata=16'hA5A5; i_stall is high until then.
- Contention: i_req and d_req rise in the same cycle, d_wr=1, d_addr 16'h0200, d_wdata 16'h1234 -> D is granted first with mem_wr=1 and mem_addr=16'h0200; I is granted one cycle after d_done. With MEM_ARB_RR_EN defined, I is granted first.
- Timeout: grant D, mem_done never asserted -> after 15 BUSY cycles, err=1, d_done pulses with d_rdata=0, FSM back in IDLE. A later mem_done is ignored and err stays 1.
- Protocol violation: change i_addr from 16'h0010 to 16'h0012 while BUSY_I -> err=1 on the next cycle; the transaction still completes normally.
- Reset mid-access: assert rst while BUSY_D -> all outputs go to 0 asynchronously. After rst is released, mem_done is ignored without error and a new i_req is granted normally.
- Back-to-back: hold d_req across two accesses with 1-cycle memory -> mem_en pulses are 3 cycles apart; no duplicate grant occurs in the done cycle.
